tick_gen: RTL and testbench
===========================

Name: tick_gen

Overview:
- Parametrised successor to the game/display clock divider: N independent programmable tick channels plus a free-running divider bus.
- Each channel issues single-cycle enable strobes at a period derived from a per-channel base, a per-channel step and a shared difficulty level (score). The period saturates and changes without glitches.
- Sits between the top level and the game FSM, VGA and seven-segment logic. Consumers use the tick strobes as clock enables on clk instead of using derived clocks.

Parameters:
- NCH, 2, number of tick channels (1..8)
- CNT_W, 20, period counter width in bits
- STEP_W, 10, per-channel step width in bits
- LVL_W, 10, level (score) width in bits
- DIV_W, 18, free-running divider width in bits
- MIN_PERIOD, 2, saturation floor for the effective period (>=1)
- DEF_BASE, 500000, reset value of every channel's base

Ports:
- clk  in  1  master clock (50 MHz)
- clr  in  1  asynchronous, active-low reset
- level  in  LVL_W  difficulty level (score), unsigned
- cfg_we  in  1  config write strobe
- cfg_ch  in  $clog2(NCH)  channel selected by cfg_we
- cfg_base  in  CNT_W  base period written to the channel
- cfg_step  in  STEP_W  step per level written to the channel
- cfg_mode  in  1  0 = periodic, 1 = one-shot
- ch_en  in  NCH  per-channel enable
- start  in  NCH  one-shot arm pulses
- tick  out  NCH  single-cycle tick strobes
- busy  out  NCH  channel is in RUN
- div_q  out  DIV_W  free-running divider (div_q[1] is the pixel enable source, div_q[17] the segment scan source)

Behaviour:
- Reset (clr low, asynchronous):
  - div_q = 0; tick = 0; busy = 0.
  - All counters = 0; all states IDLE.
  - base = DEF_BASE, step = 0, mode = periodic, active period = DEF_BASE.
- div_q increments by 1 every cycle and wraps modulo 2^DIV_W.
- Effective period, computed combinationally per channel:
  - prod = step*level, held in STEP_W+LVL_W bits with no truncation.
  - If base < prod + MIN_PERIOD, eff = MIN_PERIOD; otherwise eff = base - prod.
  - No underflow and no wrap under any input.
- Config write: when cfg_we=1, channel cfg_ch loads base, step and mode at the clock edge. Mode is sampled only on the IDLE->RUN transition.
- Active period (shadow register):
  - Loads eff on the IDLE->RUN transition and on every tick cycle.
  - A change to level or config never alters the period currently in progress.
- Channel FSM, states IDLE and RUN:
  - IDLE->RUN, periodic: ch_en=1.
  - IDLE->RUN, one-shot: ch_en=1 and start=1.
  - On entry to RUN the counter is 0.
  - In RUN the counter increments each cycle. tick=1 in the cycle where counter == active-1; the counter then returns to 0.
  - Periodic mode stays in RUN.
  - One-shot mode returns to IDLE after its single tick.
  - ch_en=0 forces IDLE and counter 0 on the next edge, with no tick in that cycle. This has priority over tick.
  - start in RUN is ignored. start with ch_en=0 is ignored.
- Latency: with ch_en (or start) sampled at edge 0, the first tick is high in cycle P (edge P). Later periodic ticks follow every P cycles.
- A cfg write to a running channel in the same cycle as its tick: the tick still fires, and the new base/step feed the next period because eff is recomputed from the just-written registers one cycle later. The period latched at that tick uses the old config.
- busy is registered and equals (state==RUN). tick is registered.
- Reset mid-period: everything returns to reset values immediately, with no trailing tick.

Decomposition:
- Package tick_gen_pkg:
  - chan_state_t enum {IDLE, RUN}
  - mode_t enum {PERIODIC, ONESHOT}
  - function sat_period(base, step, level, MIN_PERIOD)
- Sub-module tick_chan: one channel holding its config regs, shadow period, counter and FSM. It is instantiated NCH times in a generate loop.
- div_q lives in the top level.

Test Plan:
- Reset held low for 5 cycles, then released -> all outputs 0. After 5 further cycles div_q == 5 (counting starts after release).
- ch0: base=10, step=2, level=3, ch_en[0] raised at edge 0 -> P=4; tick[0] at cycles 4, 8, 12; busy[0]=1 from cycle 1.
- Same setup, but level switched to 6 at cycle 6 -> tick at 8 (old period). After that, eff = 10-12 saturates to MIN_PERIOD=2, giving ticks at 10, 12, 14.
- ch1 one-shot: base=5, step=0, start[1] pulsed at edge 0 -> single tick at cycle 5, busy[1] falls at edge 6. A second start pulsed at cycle 3 is ignored.
- ch_en[0] dropped in the cycle where counter == active-1 -> no tick; busy 0 next cycle. Re-enabling restarts the period from 0.
- clr asserted at cycle 3 of a P=4 period -> tick never asserts. After release, ch0 (still enabled) reloads DEF_BASE and step=0.

Source files
------------

// File: rtl/tick_gen_pkg.sv
// Shared types and the period saturation helper for the tick generator.
package tick_gen_pkg;

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} chan_state_t;
  typedef enum logic {PERIODIC = 1'b0, ONESHOT = 1'b1} mode_t;

  // Wide enough to hold step*level plus the floor for any legal width mix.
  localparam int SAT_W = 64;

  // Effective period: base - step*level, floored at min_period, never wraps.
  function automatic logic [SAT_W-1:0] sat_period(
    input logic [SAT_W-1:0] base,
    input logic [SAT_W-1:0] step,
    input logic [SAT_W-1:0] level,
    input logic [SAT_W-1:0] min_period
  );
    logic [SAT_W-1:0] prod;
    prod = step * level;
    if (base < prod + min_period) begin
      return min_period;
    end
    return base - prod;
  endfunction

endpackage

// File: rtl/tick_gen_if.sv
// Channel configuration bus: one write strobe addressing a single channel.
interface tick_gen_if
  import tick_gen_pkg::*;
#(
  parameter int NCH    = 2,
  parameter int CNT_W  = 20,
  parameter int STEP_W = 10
);
  localparam int CH_W = (NCH > 1) ? $clog2(NCH) : 1;

  logic              cfg_we;
  logic [CH_W-1:0]   cfg_ch;
  logic [CNT_W-1:0]  cfg_base;
  logic [STEP_W-1:0] cfg_step;
  mode_t             cfg_mode;

  modport master (
    output cfg_we, cfg_ch, cfg_base, cfg_step, cfg_mode
  );

  modport slave (
    input cfg_we, cfg_ch, cfg_base, cfg_step, cfg_mode
  );

endinterface

// File: rtl/tick_chan.sv
// One tick channel: config registers, shadow period, period counter and
// IDLE/RUN control. Emits a registered single-cycle tick at the end of
// each period.
module tick_chan
  import tick_gen_pkg::*;
#(
  parameter int CNT_W      = 20,
  parameter int STEP_W     = 10,
  parameter int LVL_W      = 10,
  parameter int MIN_PERIOD = 2,
  parameter int DEF_BASE   = 500000
) (
  input  logic              clk,
  input  logic              clr,
  input  logic [LVL_W-1:0]  level,
  input  logic              cfg_we,
  input  logic [CNT_W-1:0]  cfg_base,
  input  logic [STEP_W-1:0] cfg_step,
  input  mode_t             cfg_mode,
  input  logic              ch_en,
  input  logic              start,
  output logic              tick,
  output logic              busy
);

  logic [CNT_W-1:0]  base_q, base_d;
  logic [STEP_W-1:0] step_q, step_d;
  mode_t             mode_q, mode_d;
  mode_t             run_mode_q, run_mode_d;
  chan_state_t       state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CNT_W-1:0]  active_q, active_d;
  logic              tick_q, tick_d;
  logic              busy_q, busy_d;
  logic [CNT_W-1:0]  eff;

  // Period the next run would use, from the registered config and live level.
  assign eff = CNT_W'(sat_period(SAT_W'(base_q), SAT_W'(step_q),
                                 SAT_W'(level), SAT_W'(MIN_PERIOD)));

  // Config writes, shadow reload and IDLE/RUN next-state; ch_en=0 beats tick.
  always_comb begin
    base_d     = base_q;
    step_d     = step_q;
    mode_d     = mode_q;
    run_mode_d = run_mode_q;
    state_d    = state_q;
    cnt_d      = cnt_q;
    active_d   = active_q;
    tick_d     = 1'b0;
    busy_d     = (state_q == RUN);
    if (cfg_we) begin
      base_d = cfg_base;
      step_d = cfg_step;
      mode_d = cfg_mode;
    end
    case (state_q)
      IDLE: begin
        if (ch_en && (mode_q == PERIODIC || start)) begin
          state_d    = RUN;
          cnt_d      = '0;
          active_d   = eff;
          run_mode_d = mode_q;
        end
      end
      RUN: begin
        if (!ch_en) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == active_q - CNT_W'(1)) begin
          tick_d   = 1'b1;
          cnt_d    = '0;
          active_d = eff;
          if (run_mode_q == ONESHOT) begin
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State register; clr drops everything back to defaults immediately.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      base_q     <= CNT_W'(DEF_BASE);
      step_q     <= '0;
      mode_q     <= PERIODIC;
      run_mode_q <= PERIODIC;
      state_q    <= IDLE;
      cnt_q      <= '0;
      active_q   <= CNT_W'(DEF_BASE);
      tick_q     <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      base_q     <= base_d;
      step_q     <= step_d;
      mode_q     <= mode_d;
      run_mode_q <= run_mode_d;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      active_q   <= active_d;
      tick_q     <= tick_d;
      busy_q     <= busy_d;
    end
  end

  assign tick = tick_q;
  assign busy = busy_q;

endmodule

// File: rtl/tick_gen.sv
// Tick generator top: NCH programmable tick channels plus the free-running
// divider that feeds pixel and segment-scan enables.
module tick_gen
  import tick_gen_pkg::*;
#(
  parameter int NCH        = 2,
  parameter int CNT_W      = 20,
  parameter int STEP_W     = 10,
  parameter int LVL_W      = 10,
  parameter int DIV_W      = 18,
  parameter int MIN_PERIOD = 2,
  parameter int DEF_BASE   = 500000
) (
  input  logic             clk,
  input  logic             clr,
  input  logic [LVL_W-1:0] level,
  tick_gen_if.slave        cfg,
  input  logic [NCH-1:0]   ch_en,
  input  logic [NCH-1:0]   start,
  output logic [NCH-1:0]   tick,
  output logic [NCH-1:0]   busy,
  output logic [DIV_W-1:0] div_q
);

  localparam int CH_W = (NCH > 1) ? $clog2(NCH) : 1;

  logic [DIV_W-1:0] div_d;

  // Divider advances every cycle and wraps naturally.
  always_comb begin
    div_d = div_q + DIV_W'(1);
  end

  // Divider register.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      div_q <= '0;
    end else begin
      div_q <= div_d;
    end
  end

  for (genvar i = 0; i < NCH; i++) begin : g_chan
    logic we_i;
    assign we_i = cfg.cfg_we && (cfg.cfg_ch == CH_W'(i));

    tick_chan #(
      .CNT_W     (CNT_W),
      .STEP_W    (STEP_W),
      .LVL_W     (LVL_W),
      .MIN_PERIOD(MIN_PERIOD),
      .DEF_BASE  (DEF_BASE)
    ) u_chan (
      .clk     (clk),
      .clr     (clr),
      .level   (level),
      .cfg_we  (we_i),
      .cfg_base(cfg.cfg_base),
      .cfg_step(cfg.cfg_step),
      .cfg_mode(cfg.cfg_mode),
      .ch_en   (ch_en[i]),
      .start   (start[i]),
      .tick    (tick[i]),
      .busy    (busy[i])
    );
  end

endmodule

// File: tb/tb_tick_gen.sv
// Bench for tick_gen: directed vector tables, hand-written corner sequences
// and a randomized run checked against an absolute-time reference model.
module tb_tick_gen;
  import tick_gen_pkg::*;

  localparam int NCH = 2, CNT_W = 20, STEP_W = 10, LVL_W = 10, DIV_W = 18;
  localparam int MIN_P = 2, DEF_B = 500000;

  logic             clk = 1'b0;
  logic             clr = 1'b0;
  logic [LVL_W-1:0] level = '0;
  logic [NCH-1:0]   ch_en = '0;
  logic [NCH-1:0]   start = '0;
  logic [NCH-1:0]   tick;
  logic [NCH-1:0]   busy;
  logic [DIV_W-1:0] div_q;

  tick_gen_if #(.NCH(NCH), .CNT_W(CNT_W), .STEP_W(STEP_W)) cfg_if ();

  tick_gen #(
    .NCH(NCH), .CNT_W(CNT_W), .STEP_W(STEP_W), .LVL_W(LVL_W),
    .DIV_W(DIV_W), .MIN_PERIOD(MIN_P), .DEF_BASE(DEF_B)
  ) dut (
    .clk(clk), .clr(clr), .level(level), .cfg(cfg_if),
    .ch_en(ch_en), .start(start), .tick(tick), .busy(busy), .div_q(div_q)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  // Edges since the last reset release, for the divider check.
  longint ecount;
  always @(posedge clk or negedge clr) begin
    if (!clr) ecount <= 0;
    else      ecount <= ecount + 1;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    ch_en = '0;
    start = '0;
    repeat (n) step();
  endtask

  task automatic cfg_write(input int ch, input int base, input int stp, input mode_t m);
    cfg_if.cfg_we   = 1'b1;
    cfg_if.cfg_ch   = 1'(ch);
    cfg_if.cfg_base = CNT_W'(base);
    cfg_if.cfg_step = STEP_W'(stp);
    cfg_if.cfg_mode = m;
    step();
    cfg_if.cfg_we = 1'b0;
  endtask

  // Vector table: inputs applied before edge n, outputs expected after it.
  typedef struct packed {
    logic [NCH-1:0]   en;
    logic [NCH-1:0]   st;
    logic [LVL_W-1:0] lvl;
    logic [NCH-1:0]   tk;
    logic [NCH-1:0]   bz;
  } vec_t;
  vec_t vq[$];

  task automatic run_table(input string nm);
    for (int r = 0; r < vq.size(); r++) begin
      ch_en = vq[r].en;
      start = vq[r].st;
      level = vq[r].lvl;
      step();
      chk($sformatf("%s_tick[%0d]", nm, r), 64'(tick), 64'(vq[r].tk));
      chk($sformatf("%s_busy[%0d]", nm, r), 64'(busy), 64'(vq[r].bz));
    end
    vq.delete();
  endtask

  // Reference model: tracks the absolute edge of each channel's next tick.
  longint m_now;
  longint m_next [NCH];
  bit     m_run  [NCH];
  bit     m_om   [NCH];
  longint m_base [NCH];
  longint m_step [NCH];
  bit     m_mode [NCH];
  logic [NCH-1:0] m_tick, m_busy;

  function automatic longint m_eff(input longint b, input longint s, input longint l);
    longint e;
    e = b - s * l;
    return (e < MIN_P) ? longint'(MIN_P) : e;
  endfunction

  task automatic model_edge();
    for (int i = 0; i < NCH; i++) begin
      m_tick[i] = m_run[i] && ch_en[i] && (m_now == m_next[i]);
      m_busy[i] = m_run[i];
      if (!m_run[i]) begin
        if (ch_en[i] && (!m_mode[i] || start[i])) begin
          m_run[i]  = 1'b1;
          m_om[i]   = m_mode[i];
          m_next[i] = m_now + m_eff(m_base[i], m_step[i], longint'(level));
        end
      end else if (!ch_en[i]) begin
        m_run[i] = 1'b0;
      end else if (m_now == m_next[i]) begin
        if (m_om[i]) m_run[i] = 1'b0;
        else m_next[i] = m_now + m_eff(m_base[i], m_step[i], longint'(level));
      end
    end
    if (cfg_if.cfg_we) begin
      m_base[cfg_if.cfg_ch] = longint'(cfg_if.cfg_base);
      m_step[cfg_if.cfg_ch] = longint'(cfg_if.cfg_step);
      m_mode[cfg_if.cfg_ch] = (cfg_if.cfg_mode == ONESHOT);
    end
    m_now++;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    cfg_if.cfg_we   = 1'b0;
    cfg_if.cfg_ch   = '0;
    cfg_if.cfg_base = '0;
    cfg_if.cfg_step = '0;
    cfg_if.cfg_mode = PERIODIC;

    // Reset held for 5 cycles, then divider counts from release.
    repeat (5) step();
    chk("rst_tick", 64'(tick), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_div", 64'(div_q), 64'd0);
    @(negedge clk);
    clr = 1'b1;
    repeat (5) step();
    chk("div_after_release", 64'(div_q), 64'd5);
    chk("idle_tick", 64'(tick), 64'd0);

    level = 10'd3;
    cfg_write(0, 10, 2, PERIODIC);
    cfg_write(1, 5, 0, ONESHOT);

    // ch0 periodic: 10 - 2*3 = 4.
    for (int n = 0; n <= 14; n++)
      vq.push_back('{en: 2'b01, st: 2'b00, lvl: 10'd3,
                     tk: {1'b0, (n == 4 || n == 8 || n == 12)},
                     bz: {1'b0, (n >= 1)}});
    run_table("ch0_periodic");
    idle(3);

    // Level raised mid-period: old period holds, then saturates to 2.
    for (int n = 0; n <= 15; n++)
      vq.push_back('{en: 2'b01, st: 2'b00, lvl: (n >= 7) ? 10'd6 : 10'd3,
                     tk: {1'b0, (n == 4 || n == 8 || n == 10 || n == 12 || n == 14)},
                     bz: {1'b0, (n >= 1)}});
    run_table("ch0_level_change");
    idle(3);

    // ch1 one-shot, base 5; the re-start at n=3 is ignored.
    for (int n = 0; n <= 9; n++)
      vq.push_back('{en: 2'b10, st: {(n == 0 || n == 3), 1'b0}, lvl: 10'd3,
                     tk: {(n == 5), 1'b0},
                     bz: {(n >= 1 && n <= 5), 1'b0}});
    run_table("ch1_oneshot");
    idle(3);

    // ch_en dropped on the would-be tick edge, re-enabled two cycles later.
    for (int n = 0; n <= 10; n++) begin
      ch_en[0] = !(n == 4 || n == 5);
      step();
      chk($sformatf("en_drop_tick[%0d]", n), 64'(tick[0]), 64'(n == 10));
      if (n == 5) chk("en_drop_busy_low", 64'(busy[0]), 64'd0);
      if (n == 7) chk("en_drop_busy_back", 64'(busy[0]), 64'd1);
    end
    idle(3);

    // Config rewritten on the tick edge: one more old period, then 20.
    for (int n = 0; n <= 29; n++) begin
      ch_en[0] = 1'b1;
      cfg_if.cfg_we   = (n == 4);
      cfg_if.cfg_ch   = 1'b0;
      cfg_if.cfg_base = CNT_W'(20);
      cfg_if.cfg_step = '0;
      cfg_if.cfg_mode = PERIODIC;
      step();
      chk($sformatf("cfg_on_tick[%0d]", n), 64'(tick[0]), 64'(n == 4 || n == 8 || n == 28));
    end
    cfg_if.cfg_we = 1'b0;
    idle(3);
    cfg_write(0, 10, 2, PERIODIC);

    // Reset in cycle 3 of a 4-cycle period: no trailing tick.
    ch_en[0] = 1'b1;
    repeat (4) step();
    #2;
    clr = 1'b0;
    #1;
    chk("clr_mid_tick", 64'(tick), 64'd0);
    chk("clr_mid_busy", 64'(busy), 64'd0);
    chk("clr_mid_div", 64'(div_q), 64'd0);
    for (int k = 0; k < 3; k++) begin
      step();
      chk($sformatf("clr_hold_tick[%0d]", k), 64'(tick), 64'd0);
    end
    @(negedge clk);
    clr = 1'b1;
    for (int k = 0; k < 20; k++) begin
      step();
      chk($sformatf("post_clr_tick[%0d]", k), 64'(tick), 64'd0);
      if (k == 0) chk("post_clr_busy0", 64'(busy[0]), 64'd0);
      if (k == 1) chk("post_clr_busy1", 64'(busy[0]), 64'd1);
    end
    idle(3);

    // Randomized run from the post-reset config against the model.
    m_now = 0;
    for (int i = 0; i < NCH; i++) begin
      m_run[i] = 1'b0; m_om[i] = 1'b0; m_next[i] = 0;
      m_base[i] = DEF_B; m_step[i] = 0; m_mode[i] = 1'b0;
    end
    for (int it = 0; it < 1500; it++) begin
      for (int i = 0; i < NCH; i++) begin
        ch_en[i] = ($urandom_range(15) != 0);
        start[i] = ($urandom_range(3) == 0);
      end
      if ($urandom_range(7) == 0)
        level = ($urandom_range(9) == 0) ? 10'h3FF : LVL_W'($urandom_range(7));
      cfg_if.cfg_we   = ($urandom_range(7) == 0);
      cfg_if.cfg_ch   = 1'($urandom_range(NCH - 1));
      cfg_if.cfg_base = CNT_W'($urandom_range(24));
      cfg_if.cfg_step = STEP_W'($urandom_range(3));
      cfg_if.cfg_mode = mode_t'($urandom_range(1));
      model_edge();
      step();
      chk("rand_tick", 64'(tick), 64'(m_tick));
      chk("rand_busy", 64'(busy), 64'(m_busy));
      chk("rand_div", 64'(div_q), 64'(ecount & ((64'd1 << DIV_W) - 1)));
    end
    cfg_if.cfg_we = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
